// File: rtl/aes_pkg.sv
// aes_pkg: AES encipher encodings, round counts and the GF(2^8) round helpers
package aes_pkg;
    localparam logic [1:0] KEYLEN_128 = 2'd0;
    localparam logic [1:0] KEYLEN_256 = 2'd1;
    localparam logic [1:0] KEYLEN_192 = 2'd2;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;
    localparam logic [1:0] CTRL_IDLE = 2'd0;
    localparam logic [1:0] CTRL_INIT = 2'd1;
    localparam logic [1:0] CTRL_SBOX = 2'd2;
    localparam logic [1:0] CTRL_MAIN = 2'd3;
    localparam logic [2:0] UPD_NONE  = 3'd0;
    localparam logic [2:0] UPD_INIT  = 3'd1;
    localparam logic [2:0] UPD_SBOX  = 3'd2;
    localparam logic [2:0] UPD_MAIN  = 3'd3;
    localparam logic [2:0] UPD_FINAL = 3'd4;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    // Row r of column c takes the byte of column (c+r) mod 4.
    function automatic logic [127:0] shiftrows(input logic [127:0] d);
        logic [127:0] s;
        s = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[120-32*c-8*r +: 8] = d[120-32*((c+r)%4)-8*r +: 8];
        return s;
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] d);
        return {mixw(d[127:96]), mixw(d[95:64]), mixw(d[63:32]), mixw(d[31:0])};
    endfunction
endpackage

// File: rtl/aes_enc_round_logic.sv
// aes_enc_round_logic: combinational tail of a main round and of the final round
module aes_enc_round_logic
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    output logic [127:0] main_res,
    output logic [127:0] final_res
);
    always_comb begin
        main_res  = mixcolumns(shiftrows(state)) ^ round_key;
        final_res = shiftrows(state) ^ round_key;
    end
endmodule

// File: rtl/aes_encipher_block_p.sv
// aes_encipher_block_p: AES-128/192/256 encipher FSM substituting 1, 2 or 4 words per cycle
module aes_encipher_block_p
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    next,
    input  logic [1:0]              keylen,
    output logic [3:0]              round,
    input  logic [127:0]            round_key,
    output logic [32*SBOX_LANES-1:0] sboxw,
    input  logic [32*SBOX_LANES-1:0] new_sboxw,
    input  logic [127:0]            block,
    output logic [127:0]            new_block,
    output logic                    ready,
    output logic                    done
);
    localparam logic [1:0] S_LAST = 2'(4 / SBOX_LANES - 1);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
        $error("SBOX_LANES must be 1, 2 or 4");
    end

    logic [1:0]   ctrl, sword_ctr, keylen_reg, wi;
    logic [2:0]   upd;
    logic [3:0]   nr;
    logic [127:0] sbox_block, main_res, final_res, block_d;

    aes_enc_round_logic u_round (
        .state(new_block),
        .round_key(round_key),
        .main_res(main_res),
        .final_res(final_res)
    );

    // Lane j owns word sword_ctr*SBOX_LANES+j for this SBOX cycle.
    always_comb begin
        sboxw = '0;
        sbox_block = new_block;
        wi = '0;
        for (int j = 0; j < SBOX_LANES; j++) begin
            wi = 2'(int'(sword_ctr) * SBOX_LANES + j);
            sboxw[32*j +: 32] = ctrl == CTRL_SBOX ? new_block[32*(3-int'(wi)) +: 32] : 32'h0;
            sbox_block[32*(3-int'(wi)) +: 32] = new_sboxw[32*j +: 32];
        end
    end

    always_comb begin
        nr = keylen_reg == KEYLEN_256 ? NR_256 : keylen_reg == KEYLEN_192 ? NR_192 : NR_128;
        upd = ctrl == CTRL_INIT ? UPD_INIT :
              ctrl == CTRL_SBOX ? UPD_SBOX :
              ctrl == CTRL_MAIN ? (round == nr ? UPD_FINAL : UPD_MAIN) : UPD_NONE;
        block_d = upd == UPD_INIT  ? block ^ round_key :
                  upd == UPD_SBOX  ? sbox_block :
                  upd == UPD_MAIN  ? main_res :
                  upd == UPD_FINAL ? final_res : new_block;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl       <= CTRL_IDLE;
            round      <= 4'd0;
            sword_ctr  <= 2'd0;
            new_block  <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
            keylen_reg <= KEYLEN_128;
        end else begin
            new_block <= block_d;
            done      <= 1'b0;
            case (ctrl)
                CTRL_IDLE: if (next) begin
                    round      <= 4'd0;
                    keylen_reg <= keylen;
                    ready      <= 1'b0;
                    ctrl       <= CTRL_INIT;
                end
                CTRL_INIT: begin
                    round     <= round + 4'd1;
                    sword_ctr <= 2'd0;
                    ctrl      <= CTRL_SBOX;
                end
                CTRL_SBOX: begin
                    sword_ctr <= sword_ctr == S_LAST ? 2'd0 : sword_ctr + 2'd1;
                    ctrl      <= sword_ctr == S_LAST ? CTRL_MAIN : CTRL_SBOX;
                end
                default: begin
                    // After the final round, round is left at Nr+1 until the next start.
                    round     <= round + 4'd1;
                    sword_ctr <= 2'd0;
                    ready     <= round == nr;
                    done      <= round == nr;
                    ctrl      <= round == nr ? CTRL_IDLE : CTRL_SBOX;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encipher_block_p.sv
// tb_aes_encipher_block_p: byte-level AES reference model checking 1, 2 and 4 lane encipher instances
module tb_aes_encipher_block_p;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam int SV [3] = '{4, 2, 1};
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         nxt [3];
    logic [1:0]   kl [3];
    logic [127:0] pt;
    logic [3:0]   rnd [3];
    logic         rdy [3];
    logic         dn [3];
    logic         sbz [3];
    logic [127:0] nb [3];
    logic [127:0] rkey [3];
    logic [31:0]  sbw1, nsb1;
    logic [63:0]  sbw2, nsb2;
    logic [127:0] sbw4, nsb4;
    logic [7:0]   sb [256];
    logic [127:0] rk [3][16];
    int n_pass = 0;
    int n_tot = 0;
    bit chk_en = 1'b0;

    int           m_e [3];
    int           m_total [3];
    logic         m_done [3];
    logic [127:0] m_exp [3];
    logic [127:0] m_blk [3];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h0; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic int nr_of(input logic [1:0] k);
        return k == 2'd1 ? 14 : k == 2'd2 ? 12 : 10;
    endfunction

    function automatic logic [127:0] aes_ref(input int i, input logic [127:0] p, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] x;
        x = p ^ rk[i][0];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sb[x[127-8*k -: 8]];
            for (int k = 0; k < 16; k++) t[k] = s[4*((k/4 + k%4) % 4) + k%4];
            if (r < nr) for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                t[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
            end
            for (int k = 0; k < 16; k++) x[127-8*k -: 8] = t[k];
            x = x ^ rk[i][r];
        end
        return x;
    endfunction

    task automatic load_key(input int i, input logic [255:0] key, input logic [1:0] k);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0] rc;
        int nk, nr;
        nk = k == 2'd1 ? 8 : k == 2'd2 ? 6 : 4;
        nr = nk + 6;
        rc = 8'h01;
        for (int n = 0; n < 64; n++) w[n] = '0;
        for (int n = 0; n < 4*(nr+1); n++) begin
            if (n < nk) w[n] = key[255-32*n -: 32];
            else begin
                t = w[n-1];
                if (n % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 2);
                end else if (nk > 6 && n % nk == 4) t = subw(t);
                w[n] = w[n-nk] ^ t;
            end
        end
        for (int r = 0; r < 16; r++)
            rk[i][r] = r <= nr ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic check(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h at %0t", nm, i, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    always_comb for (int i = 0; i < 3; i++) rkey[i] = rk[i][rnd[i]];
    assign nsb1 = subw(sbw1);
    assign nsb2 = {subw(sbw2[63:32]), subw(sbw2[31:0])};
    assign nsb4 = {subw(sbw4[127:96]), subw(sbw4[95:64]), subw(sbw4[63:32]), subw(sbw4[31:0])};
    assign sbz[0] = sbw1 == '0;
    assign sbz[1] = sbw2 == '0;
    assign sbz[2] = sbw4 == '0;

    aes_encipher_block_p #(.SBOX_LANES(1)) u1 (
        .clk(clk), .reset(rst), .next(nxt[0]), .keylen(kl[0]), .round(rnd[0]), .round_key(rkey[0]),
        .sboxw(sbw1), .new_sboxw(nsb1), .block(pt), .new_block(nb[0]), .ready(rdy[0]), .done(dn[0]));
    aes_encipher_block_p #(.SBOX_LANES(2)) u2 (
        .clk(clk), .reset(rst), .next(nxt[1]), .keylen(kl[1]), .round(rnd[1]), .round_key(rkey[1]),
        .sboxw(sbw2), .new_sboxw(nsb2), .block(pt), .new_block(nb[1]), .ready(rdy[1]), .done(dn[1]));
    aes_encipher_block_p #(.SBOX_LANES(4)) u4 (
        .clk(clk), .reset(rst), .next(nxt[2]), .keylen(kl[2]), .round(rnd[2]), .round_key(rkey[2]),
        .sboxw(sbw4), .new_sboxw(nsb4), .block(pt), .new_block(nb[2]), .ready(rdy[2]), .done(dn[2]));

    // Model: a start occupies Nr*(S+1)+1 cycles; the ciphertext lands on the last of them.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            m_done[i] <= 1'b0;
            if (rst) begin
                m_e[i] <= 0;
                m_total[i] <= 0;
                m_blk[i] <= '0;
            end else if (m_e[i] < m_total[i]) begin
                m_e[i] <= m_e[i] + 1;
                if (m_e[i] + 1 == m_total[i]) begin
                    m_done[i] <= 1'b1;
                    m_blk[i] <= m_exp[i];
                end
            end else if (nxt[i]) begin
                m_total[i] <= nr_of(kl[i]) * (SV[i] + 1) + 1;
                m_e[i] <= 0;
                m_exp[i] <= aes_ref(i, pt, nr_of(kl[i]));
            end
        end
    end

    function automatic int exp_round(input int i);
        if (m_total[i] == 0 || m_e[i] == 0) return 0;
        return 1 + (m_e[i] - 1) / (SV[i] + 1);
    endfunction

    function automatic bit in_sbox(input int i);
        return m_e[i] < m_total[i] && m_e[i] > 0 && (m_e[i] - 1) % (SV[i] + 1) < SV[i];
    endfunction

    always @(negedge clk) begin
        if (chk_en) for (int i = 0; i < 3; i++) begin
            check("ready", i, 128'(rdy[i]), 128'(m_e[i] >= m_total[i]));
            check("done", i, 128'(dn[i]), 128'(m_done[i]));
            check("round", i, 128'(rnd[i]), 128'(exp_round(i)));
            if (m_e[i] >= m_total[i]) check("new_block", i, nb[i], m_blk[i]);
            if (!in_sbox(i)) check("sboxw_zero", i, 128'(sbz[i]), 128'(1));
        end
    end

    task automatic run(input int i, input logic [1:0] k, input logic [127:0] ct, input int len);
        int cnt, dones;
        logic [15:0] seen;
        kl[i] = k;
        nxt[i] = 1'b1;
        tick;
        nxt[i] = 1'b0;
        cnt = 0; dones = 0; seen = '0;
        seen[rnd[i]] = 1'b1;
        while (!rdy[i] && cnt < 400) begin
            tick;
            cnt++;
            seen[rnd[i]] = 1'b1;
            dones += int'(dn[i]);
        end
        check("busy_len", i, 128'(cnt), 128'(len));
        check("ciphertext", i, nb[i], ct);
        check("rounds_seen", i, 128'(seen), 128'((1 << (nr_of(k) + 2)) - 1));
        check("done_pulses", i, 128'(dones), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] inv, b;
        int cnt, dones;
        for (int i = 0; i < 3; i++) begin nxt[i] = 1'b0; kl[i] = 2'd0; end
        pt = PT;
        for (int x = 0; x < 256; x++) begin
            b = 8'(x);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        load_key(0, K128, 2'd0);
        load_key(1, K192, 2'd2);
        load_key(2, K256, 2'd1);
        check("model_sbox00", 0, 128'(sb[0]), 128'(8'h63));
        check("model_sbox53", 0, 128'(sb[8'h53]), 128'(8'hed));
        check("model_rk10", 0, rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("model_aes128", 0, aes_ref(0, PT, 10), CT128);
        check("model_aes192", 1, aes_ref(1, PT, 12), CT192);
        check("model_aes256", 2, aes_ref(2, PT, 14), CT256);

        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk_en = 1'b1;
        tick;

        run(0, 2'd0, CT128, 51);
        run(1, 2'd2, CT192, 37);
        run(2, 2'd1, CT256, 29);

        // next and keylen churn while busy must not disturb the run
        kl[0] = 2'd0;
        nxt[0] = 1'b1;
        tick;
        cnt = 0; dones = 0;
        while (!rdy[0] && cnt < 400) begin
            nxt[0] = ~nxt[0];
            kl[0] = kl[0] + 2'd1;
            tick;
            cnt++;
            dones += int'(dn[0]);
        end
        nxt[0] = 1'b0;
        kl[0] = 2'd0;
        check("churn_len", 0, 128'(cnt), 128'(51));
        check("churn_ct", 0, nb[0], CT128);
        check("churn_done", 0, 128'(dones), 128'(1));
        tick;

        // abort at round 5
        nxt[0] = 1'b1;
        tick;
        nxt[0] = 1'b0;
        cnt = 0; dones = 0;
        while (rnd[0] != 4'd5 && cnt < 400) begin
            tick;
            cnt++;
            dones += int'(dn[0]);
        end
        check("reach_round5", 0, 128'(rnd[0]), 128'(5));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_ready", 0, 128'(rdy[0]), 128'(1));
        check("abort_block", 0, nb[0], 128'h0);
        check("abort_round", 0, 128'(rnd[0]), 128'(0));
        for (int k = 0; k < 3; k++) begin
            tick;
            dones += int'(dn[0]);
        end
        check("abort_no_done", 0, 128'(dones), 128'(0));

        run(0, 2'd0, CT128, 51);
        run(0, 2'd3, CT128, 51);

        // next held high across done restarts one cycle later
        kl[0] = 2'd0;
        nxt[0] = 1'b1;
        tick;
        cnt = 0;
        while (!rdy[0] && cnt < 400) begin tick; cnt++; end
        check("b2b_len1", 0, 128'(cnt), 128'(51));
        check("b2b_ct1", 0, nb[0], CT128);
        check("b2b_done1", 0, 128'(dn[0]), 128'(1));
        tick;
        nxt[0] = 1'b0;
        check("b2b_restart", 0, 128'(rdy[0]), 128'(0));
        cnt = 0;
        while (!rdy[0] && cnt < 400) begin tick; cnt++; end
        check("b2b_len2", 0, 128'(cnt), 128'(51));
        check("b2b_ct2", 0, nb[0], CT128);

        tick;
        tick;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/aes_encipher_block_p.md
Name: aes_encipher_block_p

Overview:
Parametrised next-generation AES encipher datapath/FSM for the core. It applies the initial, main and final AES rounds to a 128-bit block under an external key memory (round/round_key) and external S-box lanes (sboxw/new_sboxw). It generalises SubBytes throughput to 1, 2 or 4 words per cycle and adds AES-192 support. It also latches the key length at start, ignores next while busy, and emits a one-cycle done pulse.

Parameters:
SBOX_LANES, 1, number of 32-bit S-box words substituted per cycle; legal values 1, 2, 4 (others: elaboration error)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous active-high reset
next  in  1  start request; accepted only in IDLE
keylen  in  2  key length: 0=AES-128, 1=AES-256, 2=AES-192, 3=reserved (treated as AES-128); sampled on accepted next
round  out  4  current round index; external key memory returns round_key combinationally, same cycle
round_key  in  128  round key for index "round"
sboxw  out  32*SBOX_LANES  words to substitute; lane j in bits [32j+31:32j]
new_sboxw  in  32*SBOX_LANES  combinational S-box result per lane
block  in  128  plaintext; must be stable in the INIT cycle
new_block  out  128  state/ciphertext register, word 0 = bits [127:96]
ready  out  1  high when idle
done  out  1  one-cycle pulse when the ciphertext becomes valid

Behaviour:
- Reset (sync, priority over everything): state IDLE, round=0, sword_ctr=0, new_block=0, ready=1, done=0, keylen_reg=0. Reset mid-operation aborts with no done pulse.
- S = 4/SBOX_LANES SBOX cycles per round. Nr = 10/12/14 for keylen_reg 128/192/256.
- IDLE: if next, then round_ctr:=0, keylen_reg:=keylen, ready:=0, go to INIT. Otherwise hold; next while not IDLE is ignored.
- INIT: new_block := block ^ round_key (round=0). round_ctr++, sword_ctr:=0, go to SBOX.
- SBOX: lane j drives word (sword_ctr*SBOX_LANES + j) onto sboxw; that word takes new_sboxw lane j. sword_ctr++ (mod S). When sword_ctr==S-1, go to MAIN.
- MAIN with round<Nr: new_block := MixColumns(ShiftRows(state)) ^ round_key. round++, sword_ctr:=0, go to SBOX.
- MAIN with round==Nr: new_block := ShiftRows(state) ^ round_key. ready:=1, done:=1 for one cycle, go to IDLE. round wraps to Nr+1, is not cleared, and holds until the next start.
- Latency: next sampled at edge k; ciphertext and ready=1 appear after edge k+1+Nr*(S+1). ready stays low for Nr*(S+1)+1 cycles. Examples: 51 (128-bit, 1 lane), 21 (128-bit, 4 lanes), 71 (256-bit, 1 lane).
- sboxw = 0 outside SBOX. new_block holds its value in IDLE.
- next asserted in the same cycle done pulses: the FSM is in IDLE next cycle, so next is accepted one cycle later only if still high. Back-to-back starts are legal with a 1-cycle gap.
- keylen changes during an operation have no effect.

Decomposition:
- Shared package aes_pkg:
  - keylen encodings, round counts 10/12/14
  - ctrl state encodings IDLE/INIT/SBOX/MAIN
  - update-type constants
  - functions gm2, gm3, mixw, shiftrows, mixcolumns
- One combinational sub-module aes_enc_round_logic (state, round_key -> main and final results) is natural. It is reused by a future decipher successor's test model.

Test Plan:
- AES-128, SBOX_LANES=1: FIPS-197 key 000102..0f, pt 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a. ready low exactly 51 cycles; single done pulse.
- AES-192 (keylen=2), SBOX_LANES=2: key 000102..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191. ready low 12*3+1=37 cycles.
- AES-256 (keylen=1), SBOX_LANES=4: key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089. ready low 29 cycles; round sequence 0..14 observed.
- Busy robustness: toggle next and keylen every cycle mid-run of the AES-128 vector -> result still 69c4e0d8..., no restart, one done.
- Reset mid-run at round 5 -> next cycle ready=1, new_block=0, round=0, done never pulses. A fresh run then gives the correct ciphertext.
- keylen=3 -> behaves identically to AES-128 (51 cycles, 128-bit vector result). Back-to-back: next held high -> second run starts 1 cycle after done.
